// File: rtl/sequence_lock_detector.sv
// sequence_lock_detector
// Serial receiver for a periodic LEN-bit word sent MSB first. It hunts for
// PATTERN in the bit stream, confirms alignment over LOCK_CNT clean periods,
// then tracks the phase while locked. It counts bit errors and drops lock
// after UNLOCK_ERR errors that fall in consecutive dirty periods.
module sequence_lock_detector #(
  parameter int             LEN        = 6,
  parameter logic [LEN-1:0] PATTERN    = 6'b001011,
  parameter int             LOCK_CNT   = 2,
  parameter int             UNLOCK_ERR = 3,
  parameter int             ERR_W      = 8,
  localparam int            PW         = $clog2(LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data_in,
  input  logic             data_valid,
  input  logic             err_clr,
  output logic             match,
  output logic             locked,
  output logic [PW-1:0]    phase,
  output logic             bit_err,
  output logic             lock_lost,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(UNLOCK_ERR + 1);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t           state_reg, state_next;
  logic [LEN-1:0]   sh_reg, sh_next;
  logic [PW-1:0]    phase_reg, phase_next;
  logic [GW-1:0]    good_reg, good_next;
  logic [MW-1:0]    miss_reg, miss_next;
  logic             dirty_reg, dirty_next;
  logic [ERR_W-1:0] err_reg, err_next;
  logic             match_reg, match_next;
  logic             bit_err_reg, bit_err_next;
  logic             lock_lost_reg, lock_lost_next;

  // PATTERN reversed so that phase indexes the expected bit directly
  logic [LEN-1:0] pat_rev;
  for (genvar gi = 0; gi < LEN; gi++) begin : g_rev
    assign pat_rev[gi] = PATTERN[LEN-1-gi];
  end

  logic             exp_bit;
  logic             last_bit;
  logic             mism;
  logic             dirty_now;
  logic [PW-1:0]    phase_adv;
  logic [ERR_W-1:0] err_inc;
  logic [MW-1:0]    miss_inc;
  logic [GW-1:0]    good_inc;

  assign exp_bit   = pat_rev[phase_reg];
  assign last_bit  = (phase_reg == PW'(LEN - 1));
  assign mism      = (data_in != exp_bit);
  assign dirty_now = dirty_reg | mism;
  assign phase_adv = last_bit ? '0 : phase_reg + 1'b1;
  assign err_inc   = (err_reg == {ERR_W{1'b1}}) ? err_reg : err_reg + 1'b1;
  assign miss_inc  = miss_reg + 1'b1;
  assign good_inc  = good_reg + 1'b1;

  // State register and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= HUNT;
      sh_reg        <= '0;
      phase_reg     <= '0;
      good_reg      <= '0;
      miss_reg      <= '0;
      dirty_reg     <= 1'b0;
      err_reg       <= '0;
      match_reg     <= 1'b0;
      bit_err_reg   <= 1'b0;
      lock_lost_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sh_reg        <= sh_next;
      phase_reg     <= phase_next;
      good_reg      <= good_next;
      miss_reg      <= miss_next;
      dirty_reg     <= dirty_next;
      err_reg       <= err_next;
      match_reg     <= match_next;
      bit_err_reg   <= bit_err_next;
      lock_lost_reg <= lock_lost_next;
    end
  end

  // Next-state logic: everything advances only on valid samples
  always_comb begin
    state_next     = state_reg;
    sh_next        = sh_reg;
    phase_next     = phase_reg;
    good_next      = good_reg;
    miss_next      = miss_reg;
    dirty_next     = dirty_reg;
    err_next       = err_reg;
    match_next     = 1'b0;
    bit_err_next   = 1'b0;
    lock_lost_next = 1'b0;

    if (data_valid) begin
      sh_next    = {sh_reg[LEN-2:0], data_in};
      match_next = (sh_next == PATTERN);

      unique case (state_reg)
        HUNT: begin
          if (match_next) begin
            phase_next = '0;
            if (LOCK_CNT == 1) begin
              state_next = LOCKED;
              good_next  = '0;
              miss_next  = '0;
              dirty_next = 1'b0;
            end else begin
              state_next = VERIFY;
              good_next  = GW'(1);
            end
          end
        end

        VERIFY: begin
          if (mism) begin
            // Alignment was a false start; resume hunting silently
            state_next = HUNT;
            phase_next = '0;
            good_next  = '0;
          end else begin
            phase_next = phase_adv;
            if (last_bit) begin
              if (good_inc == GW'(LOCK_CNT)) begin
                state_next = LOCKED;
                good_next  = '0;
                miss_next  = '0;
                dirty_next = 1'b0;
              end else begin
                good_next = good_inc;
              end
            end
          end
        end

        LOCKED: begin
          // Phase free-runs while locked; errors never realign it
          phase_next = phase_adv;
          if (mism) begin
            bit_err_next = 1'b1;
            err_next     = err_inc;
          end
          if (mism && miss_inc == MW'(UNLOCK_ERR)) begin
            state_next     = HUNT;
            lock_lost_next = 1'b1;
            phase_next     = '0;
            miss_next      = '0;
            dirty_next     = 1'b0;
          end else begin
            if (mism) miss_next = miss_inc;
            if (last_bit) begin
              dirty_next = 1'b0;
              // A fully clean period forgives earlier errors
              if (!dirty_now) miss_next = '0;
            end else begin
              dirty_next = dirty_now;
            end
          end
        end

        default: state_next = HUNT;
      endcase
    end

    // Clear has priority over a coincident increment
    if (err_clr) err_next = '0;
  end

  assign match     = match_reg;
  assign locked    = (state_reg == LOCKED);
  assign phase     = phase_reg;
  assign bit_err   = bit_err_reg;
  assign lock_lost = lock_lost_reg;
  assign err_cnt   = err_reg;

endmodule

// File: tb/tb_sequence_lock_detector.sv
// Testbench for sequence_lock_detector: a table of directed vectors covering
// acquisition, single errors, lock loss/relock and valid gating, followed by
// hand-written sequences for random hunting, counter saturation, clear
// priority and asynchronous reset.
module tb_sequence_lock_detector;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       data_in = 1'b0;
  logic       data_valid = 1'b0;
  logic       err_clr = 1'b0;
  logic       match;
  logic       locked;
  logic [2:0] phase;
  logic       bit_err;
  logic       lock_lost;
  logic [7:0] err_cnt;

  int n_vec  = 0;
  int n_miss = 0;
  int sidx   = 0;
  logic [5:0] pat = 6'b001011;

  sequence_lock_detector dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .err_clr    (err_clr),
    .match      (match),
    .locked     (locked),
    .phase      (phase),
    .bit_err    (bit_err),
    .lock_lost  (lock_lost),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       valid;
    logic       flip;
    logic       match;
    logic       locked;
    logic [2:0] phase;
    logic       bit_err;
    logic       lock_lost;
    logic [7:0] err_cnt;
  } vec_t;

  localparam int NT = 90;
  vec_t tbl [NT];

  function automatic logic pat_bit(input int i);
    return pat[5 - (i % 6)];
  endfunction

  function automatic bit is_flip(input int k);
    return (k == 22) || (k == 34) || (k == 40) || (k == 46);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle and sample #1 after the rising edge
  task automatic drive(input logic v, input logic d, input logic c);
    data_valid = v;
    data_in    = d;
    err_clr    = c;
    @(posedge clk);
    #1;
  endtask

  // Send the next pattern bit (optionally inverted) and advance the stream index
  task automatic send(input logic flip, input logic c);
    drive(1'b1, pat_bit(sidx) ^ flip, c);
    sidx++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    data_valid = 1'b0;
    data_in = 1'b0;
    err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.locked", 32'(locked), 0);
    check("rst.phase", 32'(phase), 0);
    check("rst.err_cnt", 32'(err_cnt), 0);
    check("rst.match", 32'(match), 0);
    rst_n = 1'b1;
    sidx = 0;
  endtask

  initial begin
    // Build the table: edges 1..66 from reset, then valid toggling
    for (int k = 1; k <= 66; k++) begin
      int ec;
      bit wflip;
      ec = 0;
      wflip = 0;
      for (int f = 1; f <= k; f++) if (is_flip(f)) ec++;
      for (int f = k - 5; f <= k; f++) if (f >= 1 && is_flip(f)) wflip = 1;
      tbl[k-1].valid     = 1'b1;
      tbl[k-1].flip      = is_flip(k);
      tbl[k-1].match     = (k % 6 == 0) && !wflip;
      tbl[k-1].locked    = (k >= 12 && k < 46) || (k >= 60);
      if (k < 6)       tbl[k-1].phase = 3'd0;
      else if (k < 46) tbl[k-1].phase = 3'((k - 6) % 6);
      else if (k < 54) tbl[k-1].phase = 3'd0;
      else             tbl[k-1].phase = 3'((k - 54) % 6);
      tbl[k-1].bit_err   = is_flip(k);
      tbl[k-1].lock_lost = (k == 46);
      tbl[k-1].err_cnt   = 8'(ec);
    end
    for (int t = 0; t < 24; t++) begin
      int j;
      j = 66 + (t + 1) / 2;
      tbl[66+t].valid     = (t % 2 == 1);
      tbl[66+t].flip      = 1'b0;
      tbl[66+t].match     = (t % 2 == 1) && (j % 6 == 0);
      tbl[66+t].locked    = 1'b1;
      tbl[66+t].phase     = 3'((j - 54) % 6);
      tbl[66+t].bit_err   = 1'b0;
      tbl[66+t].lock_lost = 1'b0;
      tbl[66+t].err_cnt   = 8'd4;
    end

    // Tests 1,2,3,5: table-driven
    do_reset();
    for (int i = 0; i < NT; i++) begin
      if (tbl[i].valid) send(tbl[i].flip, 1'b0);
      else              drive(1'b0, ~pat_bit(sidx), 1'b0);
      check($sformatf("v%0d.match", i), 32'(match), 32'(tbl[i].match));
      check($sformatf("v%0d.locked", i), 32'(locked), 32'(tbl[i].locked));
      check($sformatf("v%0d.phase", i), 32'(phase), 32'(tbl[i].phase));
      check($sformatf("v%0d.bit_err", i), 32'(bit_err), 32'(tbl[i].bit_err));
      check($sformatf("v%0d.lock_lost", i), 32'(lock_lost), 32'(tbl[i].lock_lost));
      check($sformatf("v%0d.err_cnt", i), 32'(err_cnt), 32'(tbl[i].err_cnt));
    end

    // Test 4: random bits with every PATTERN window suppressed
    do_reset();
    begin
      logic [5:0] win;
      logic b;
      win = '0;
      for (int i = 0; i < 100; i++) begin
        b = 1'($urandom_range(0, 1));
        if ({win[4:0], b} == pat) b = ~b;
        win = {win[4:0], b};
        drive(1'b1, b, 1'b0);
        check($sformatf("rnd%0d.match", i), 32'(match), 0);
        check($sformatf("rnd%0d.locked", i), 32'(locked), 0);
      end
      check("rnd.err_cnt", 32'(err_cnt), 0);
    end

    // Test 6: saturation, clear priority, relock and async reset
    do_reset();
    repeat (12) send(1'b0, 1'b0);
    check("sat.locked_start", 32'(locked), 1);
    for (int r = 0; r < 128; r++) begin
      for (int b = 0; b < 6; b++) send(b == 1 || b == 3, 1'b0);
      repeat (6) send(1'b0, 1'b0);
      check($sformatf("sat%0d.err_cnt", r), 32'(err_cnt), (2 * (r + 1) > 255) ? 255 : 2 * (r + 1));
    end
    check("sat.locked", 32'(locked), 1);
    for (int b = 0; b < 6; b++) begin
      send(b == 1 || b == 3, 1'b0);
      if (b == 1 || b == 3) begin
        check("sat.hold_bit_err", 32'(bit_err), 1);
        check("sat.hold_err_cnt", 32'(err_cnt), 255);
      end
    end
    repeat (6) send(1'b0, 1'b0);
    check("sat.locked_after", 32'(locked), 1);
    // Error and clear on the same edge: clear wins
    send(1'b0, 1'b0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b1);
    check("clr.bit_err", 32'(bit_err), 1);
    check("clr.err_cnt", 32'(err_cnt), 0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    check("clr.err_after", 32'(err_cnt), 1);
    send(1'b0, 1'b0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    check("loss.lock_lost", 32'(lock_lost), 1);
    check("loss.bit_err", 32'(bit_err), 1);
    check("loss.locked", 32'(locked), 0);
    check("loss.phase", 32'(phase), 0);
    check("loss.err_cnt", 32'(err_cnt), 2);
    send(1'b0, 1'b0);
    check("loss.pulse_end", 32'(lock_lost), 0);
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        send(1'b0, 1'b0);
        if (match) seen = 1;
      end
      check("rehunt.match_seen", 32'(seen), 1);
    end
    check("verify.locked", 32'(locked), 0);
    repeat (3) send(1'b0, 1'b0);
    check("verify.phase", 32'(phase), 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.phase", 32'(phase), 0);
    check("arst.err_cnt", 32'(err_cnt), 0);
    check("arst.locked", 32'(locked), 0);
    check("arst.lock_lost", 32'(lock_lost), 0);
    check("arst.match", 32'(match), 0);
    check("arst.bit_err", 32'(bit_err), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
